// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-to-1 W-bit multiplexer with direct-select and masked round-robin scan modes
//   clk, rst     : clock, asynchronous active-high reset
//   mode         : 0 = direct select by sel, 1 = scan over channels enabled in ch_mask
//   en           : sample strobe, one output sample per en=1 cycle
//   sel          : direct-mode channel select (sel >= N yields a zero, non-valid sample)
//   ch_mask      : scan-mode channel enables
//   din          : flattened channel data, channel k at din[k*W +: W]
//   dout/dout_ch : registered sample and its channel index
//   dout_vld     : one-cycle pulse per valid sample
//   wrap         : one-cycle pulse on the last enabled channel of a scan pass
module mux_scan_nto1 #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     ch_mask,
  input  logic [N*W-1:0]   din,
  output logic [W-1:0]     dout,
  output logic [SEL_W-1:0] dout_ch,
  output logic             dout_vld,
  output logic             wrap
);
  logic [W-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] ch_q, ch_d, ptr_q, ptr_d, start, hit_ch, top_ch;
  logic [SEL_W:0] idx;
  logic vld_q, vld_d, wrap_q, wrap_d, mode_q, hit, sel_ok;
  // A fresh entry into scan (mode_q still 0) always restarts the search at channel 0.
  assign start = mode_q ? ptr_q : '0;
  assign sel_ok = {1'b0, sel} < (SEL_W+1)'(N);
  // Highest enabled channel marks the end of a scan pass.
  always_comb begin
    top_ch = '0;
    for (int i = 0; i < N; i++)
      if (ch_mask[i]) top_ch = SEL_W'(i);
  end
  // Priority search upward from start, wrapping N-1 -> 0; first enabled channel wins.
  always_comb begin
    hit = 1'b0;
    hit_ch = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, start} + (SEL_W+1)'(i);
      idx = idx >= (SEL_W+1)'(N) ? idx - (SEL_W+1)'(N) : idx;
      if (!hit && ch_mask[idx[SEL_W-1:0]]) begin
        hit = 1'b1;
        hit_ch = idx[SEL_W-1:0];
      end
    end
  end
  always_comb begin
    dout_d = dout_q;
    ch_d = ch_q;
    vld_d = 1'b0;
    wrap_d = 1'b0;
    ptr_d = ptr_q;
    if (en && !mode) begin
      dout_d = sel_ok ? din[int'(sel)*W +: W] : '0;
      ch_d = sel;
      vld_d = sel_ok;
    end else if (en && hit) begin
      dout_d = din[int'(hit_ch)*W +: W];
      ch_d = hit_ch;
      vld_d = 1'b1;
      wrap_d = hit_ch == top_ch;
      ptr_d = hit_ch == SEL_W'(N-1) ? '0 : hit_ch + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      ch_q <= '0;
      vld_q <= 1'b0;
      wrap_q <= 1'b0;
      ptr_q <= '0;
      mode_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      ch_q <= ch_d;
      vld_q <= vld_d;
      wrap_q <= wrap_d;
      ptr_q <= ptr_d;
      mode_q <= mode;
    end
  end
  assign dout = dout_q;
  assign dout_ch = ch_q;
  assign dout_vld = vld_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb_mux_scan_nto1: randomized and directed check of mux_scan_nto1 (N=8 and N=5) against a list-based model
module tb_mux_scan_nto1;
  logic clk = 0, rst = 1, mode = 0, en = 0;
  logic [2:0] sel = 0;
  logic [7:0] mask = 0;
  logic [63:0] din = 0;
  logic [7:0] d8, d5;
  logic [2:0] c8, c5;
  logic v8, v5, w8, w5;
  int checks = 0, errors = 0;
  int m_dout[2], m_ch[2], m_vld[2], m_wrap[2], m_ptr[2], m_mq[2];
  int seq[8] = '{0, 2, 5, 7, 0, 2, 5, 7};
  always #5 clk = ~clk;
  mux_scan_nto1 #(.W(8), .N(8), .SEL_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .sel(sel), .ch_mask(mask), .din(din),
    .dout(d8), .dout_ch(c8), .dout_vld(v8), .wrap(w8));
  mux_scan_nto1 #(.W(8), .N(5), .SEL_W(3)) u_dut5 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .sel(sel), .ch_mask(mask[4:0]), .din(din[39:0]),
    .dout(d5), .dout_ch(c5), .dout_vld(v5), .wrap(w5));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_dout[d] = 0; m_ch[d] = 0; m_vld[d] = 0; m_wrap[d] = 0; m_ptr[d] = 0; m_mq[d] = 0;
    end
  endtask
  // Scan rule: take the enabled channels in ascending order, pick the first at or
  // after the start index, else wrap to the lowest; the last in the list closes a pass.
  task automatic model_clk();
    int n, s, c;
    bit found;
    int q[$];
    for (int d = 0; d < 2; d++) begin
      n = d ? 5 : 8;
      m_vld[d] = 0;
      m_wrap[d] = 0;
      if (en && !mode) begin
        m_ch[d] = sel;
        m_dout[d] = (int'(sel) < n) ? int'(din[int'(sel)*8 +: 8]) : 0;
        m_vld[d] = int'(sel) < n;
      end else if (en) begin
        s = m_mq[d] ? m_ptr[d] : 0;
        q.delete();
        for (int k = 0; k < n; k++) if (mask[k]) q.push_back(k);
        if (q.size() > 0) begin
          c = q[0];
          found = 0;
          foreach (q[i]) if (!found && q[i] >= s) begin c = q[i]; found = 1; end
          m_dout[d] = din[c*8 +: 8];
          m_ch[d] = c;
          m_vld[d] = 1;
          m_wrap[d] = c == q[q.size()-1];
          m_ptr[d] = (c + 1) % n;
        end
      end
      m_mq[d] = mode;
    end
  endtask
  task automatic compare();
    chk("dout8", d8, m_dout[0]);  chk("ch8", c8, m_ch[0]);
    chk("vld8", v8, m_vld[0]);    chk("wrap8", w8, m_wrap[0]);
    chk("dout5", d5, m_dout[1]);  chk("ch5", c5, m_ch[1]);
    chk("vld5", v5, m_vld[1]);    chk("wrap5", w5, m_wrap[1]);
  endtask
  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    compare();
  endtask
  task automatic set_inc_din();
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'h10 + 8'(k);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    compare();
    set_inc_din();
    en = 1;
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      step();
      chk("direct_dout", d8, 8'h10 + 8'(k));
    end
    din = {$urandom, $urandom};
    sel = 6; step();
    chk("oor_dout", d5, 0); chk("oor_ch", c5, 6); chk("oor_vld", v5, 0);
    sel = 4; step();
    chk("inr_dout", d5, din[39:32]); chk("inr_vld", v5, 1);
    mode = 1; mask = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      din = {$urandom, $urandom};
      step();
      chk("scan_ch", c8, seq[i]); chk("scan_wrap", w8, seq[i] == 7);
    end
    mask = 0;
    repeat (3) step();
    chk("hold_dout", d8, din[63:56]);
    mask = 8'h08;
    repeat (2) begin
      din = {$urandom, $urandom};
      step();
      chk("single_ch", c8, 3); chk("single_wrap", w8, 1);
    end
    mode = 0; en = 0; step();
    mode = 1; en = 1; mask = 8'hFF; step(); chk("gap_ch0", c8, 0);
    en = 0; step(); chk("gap_hold", c8, 0);
    en = 1; step(); chk("gap_ch1", c8, 1);
    mode = 0; sel = 6; step(); chk("toggle_ch6", c8, 6);
    mode = 1; step(); chk("restart_ch0", c8, 0);
    repeat (4) step();
    chk("pre_rst_ch", c8, 4);
    #2 rst = 1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1 rst = 0;
    step(); chk("post_rst_ch", c8, 0);
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3) != 0;
      en = $urandom_range(0, 4) != 0;
      sel = 3'($urandom);
      mask = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom & $urandom);
      din = {$urandom, $urandom};
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
